// File: rtl/sprite_compositor_if.sv
// rtl/sprite_compositor_if.sv - pixel, sprite-control and ROM signals of the sprite compositor
interface sprite_compositor_if #(
    parameter int FRAME_W = 2,
    parameter int ADDR_W  = 10
);
    logic [9:0]         x_pixel;
    logic [9:0]         y_pixel;
    logic               pix_valid;
    logic               vsync;
    logic [11:0]        bg_data;
    logic [9:0]         spr_x;
    logic [9:0]         spr_y;
    logic [FRAME_W-1:0] spr_frame;
    logic               spr_flip;
    logic               spr_en;
    logic               pos_update;
    logic [ADDR_W-1:0]  spr_addr;
    logic [11:0]        spr_data;
    logic [11:0]        pix_out;
    logic               pix_valid_out;
    logic               spr_drawn;

    // Upstream timing generator, sprite controller and ROM side
    modport master (
        output x_pixel, y_pixel, pix_valid, vsync, bg_data,
        output spr_x, spr_y, spr_frame, spr_flip, spr_en, pos_update,
        output spr_data,
        input  spr_addr, pix_out, pix_valid_out, spr_drawn
    );

    // Compositor side
    modport slave (
        input  x_pixel, y_pixel, pix_valid, vsync, bg_data,
        input  spr_x, spr_y, spr_frame, spr_flip, spr_en, pos_update,
        input  spr_data,
        output spr_addr, pix_out, pix_valid_out, spr_drawn
    );
endinterface

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - overlays one animated sprite from a synchronous ROM onto the background stream
module sprite_compositor #(
    parameter int          SPR_W   = 16,
    parameter int          SPR_H   = 16,
    parameter int          FRAME_W = 2,
    parameter int          ADDR_W  = 10,
    parameter logic [11:0] TRANSP  = 12'hF0F
) (
    input  logic               clk_25mhz,
    input  logic               Rst_n,
    sprite_compositor_if.slave bus
);
    localparam int DX_W = $clog2(SPR_W);
    localparam int DY_W = $clog2(SPR_H);

    // Shadow (written any time) and active (frame-stable) sprite state
    logic [9:0]         r_sh_x, r_sh_y, r_act_x, r_act_y;
    logic [FRAME_W-1:0] r_sh_frame, r_act_frame;
    logic               r_sh_flip, r_sh_en, r_act_flip, r_act_en;

    logic               r_vsync_q;
    logic               r_drawn_flag;
    logic               r_spr_drawn;
    logic [ADDR_W-1:0]  r_spr_addr;

    // Pipeline registers: stage 0 -> stage 1 -> output
    logic [11:0]        r_bg0, r_bg1;
    logic               r_hit0, r_hit1, r_val0, r_val1;
    logic [11:0]        r_pix_out;
    logic               r_pix_valid_out;

    logic               w_frame_start;
    logic [10:0]        w_x11, w_y11, w_ax11, w_ay11, w_x_end, w_y_end;
    logic               w_hit;
    logic [DX_W-1:0]    w_dx, w_col;
    logic [DY_W-1:0]    w_dy;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_opaque_hit;

    assign w_frame_start = r_vsync_q & ~bus.vsync;

    // 11-bit compares so the right/bottom edge never wraps at the screen border
    assign w_x11   = {1'b0, bus.x_pixel};
    assign w_y11   = {1'b0, bus.y_pixel};
    assign w_ax11  = {1'b0, r_act_x};
    assign w_ay11  = {1'b0, r_act_y};
    assign w_x_end = w_ax11 + 11'(SPR_W);
    assign w_y_end = w_ay11 + 11'(SPR_H);

    assign w_hit = bus.pix_valid & r_act_en
                 & (w_x11 >= w_ax11) & (w_x11 < w_x_end)
                 & (w_y11 >= w_ay11) & (w_y11 < w_y_end);

    assign w_dx   = DX_W'(bus.x_pixel - r_act_x);
    assign w_dy   = DY_W'(bus.y_pixel - r_act_y);
    assign w_col  = r_act_flip ? (DX_W'(SPR_W - 1) - w_dx) : w_dx;
    assign w_addr = {r_act_frame, w_dy, w_col};

    // ROM data arrives two cycles after the pixel entered, lined up with r_hit1
    assign w_opaque_hit = r_hit1 & (bus.spr_data != TRANSP);

    // Shadow registers capture the latest pos_update strobe
    always_ff @(posedge clk_25mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sh_x     <= '0;
            r_sh_y     <= '0;
            r_sh_frame <= '0;
            r_sh_flip  <= 1'b0;
            r_sh_en    <= 1'b0;
        end else if (bus.pos_update) begin
            r_sh_x     <= bus.spr_x;
            r_sh_y     <= bus.spr_y;
            r_sh_frame <= bus.spr_frame;
            r_sh_flip  <= bus.spr_flip;
            r_sh_en    <= bus.spr_en;
        end
    end

    // Active registers follow the shadow only on the vsync falling edge
    always_ff @(posedge clk_25mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_vsync_q   <= 1'b1;
            r_act_x     <= '0;
            r_act_y     <= '0;
            r_act_frame <= '0;
            r_act_flip  <= 1'b0;
            r_act_en    <= 1'b0;
        end else begin
            r_vsync_q <= bus.vsync;
            if (w_frame_start) begin
                r_act_x     <= r_sh_x;
                r_act_y     <= r_sh_y;
                r_act_frame <= r_sh_frame;
                r_act_flip  <= r_sh_flip;
                r_act_en    <= r_sh_en;
            end
        end
    end

    // Stage 0/1: register ROM address on a hit and carry bg/hit/valid along
    always_ff @(posedge clk_25mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_spr_addr <= '0;
            r_bg0      <= '0;
            r_hit0     <= 1'b0;
            r_val0     <= 1'b0;
            r_bg1      <= '0;
            r_hit1     <= 1'b0;
            r_val1     <= 1'b0;
        end else begin
            if (w_hit) begin
                r_spr_addr <= w_addr;
            end
            r_bg0  <= bus.bg_data;
            r_hit0 <= w_hit;
            r_val0 <= bus.pix_valid;
            r_bg1  <= r_bg0;
            r_hit1 <= r_hit0;
            r_val1 <= r_val0;
        end
    end

    // Stage 2: choose sprite or background, blank outside the active area
    always_ff @(posedge clk_25mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pix_out       <= '0;
            r_pix_valid_out <= 1'b0;
        end else begin
            r_pix_valid_out <= r_val1;
            if (!r_val1) begin
                r_pix_out <= '0;
            end else if (w_opaque_hit) begin
                r_pix_out <= bus.spr_data;
            end else begin
                r_pix_out <= r_bg1;
            end
        end
    end

    // Per-frame drawn flag, reported and restarted at each frame start
    always_ff @(posedge clk_25mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            r_drawn_flag <= 1'b0;
            r_spr_drawn  <= 1'b0;
        end else if (w_frame_start) begin
            r_spr_drawn  <= r_drawn_flag;
            r_drawn_flag <= w_opaque_hit;
        end else begin
            r_spr_drawn <= 1'b0;
            if (w_opaque_hit) begin
                r_drawn_flag <= 1'b1;
            end
        end
    end

    assign bus.spr_addr      = r_spr_addr;
    assign bus.pix_out       = r_pix_out;
    assign bus.pix_valid_out = r_pix_valid_out;
    assign bus.spr_drawn     = r_spr_drawn;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - scoreboard bench for sprite_compositor with directed pixel vectors
module tb_sprite_compositor;
    logic clk_25mhz = 1'b0;
    logic Rst_n     = 1'b1;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   cyc       = 0;

    typedef struct {
        logic [11:0] pix;
        int          due;
    } exp_t;
    exp_t sq[$];

    always #20 clk_25mhz = ~clk_25mhz;

    sprite_compositor_if bus ();

    sprite_compositor dut (
        .clk_25mhz (clk_25mhz),
        .Rst_n     (Rst_n),
        .bus       (bus)
    );

    always @(posedge clk_25mhz) cyc <= cyc + 1;

    // Sprite ROM: one transparent entry at 0x105, solid red elsewhere
    always @(posedge clk_25mhz) begin
        bus.spr_data <= (bus.spr_addr == 10'h105) ? 12'hF0F : 12'hF00;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard whenever a valid pixel leaves the DUT
    always @(negedge clk_25mhz) begin
        exp_t e;
        if (Rst_n) begin
            if (bus.pix_valid_out) begin
                if (sq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got %0h with empty scoreboard", bus.pix_out);
                end else begin
                    e = sq.pop_front();
                    check("pix_out", bus.pix_out, e.pix);
                    check("latency", cyc, e.due);
                end
            end else begin
                check("pix_out_blank", bus.pix_out, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk_25mhz);
        #1;
    endtask

    task automatic idle(input int n);
        bus.pix_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic px(input logic [9:0] x, input logic [9:0] y,
                      input logic [11:0] bg, input logic [11:0] exp);
        exp_t e;
        bus.x_pixel   = x;
        bus.y_pixel   = y;
        bus.bg_data   = bg;
        bus.pix_valid = 1'b1;
        e.pix = exp;
        e.due = cyc + 3;
        sq.push_back(e);
        step();
        bus.pix_valid = 1'b0;
    endtask

    task automatic load(input logic [9:0] x, input logic [9:0] y,
                        input logic [1:0] frame, input logic flip, input logic en);
        bus.spr_x      = x;
        bus.spr_y      = y;
        bus.spr_frame  = frame;
        bus.spr_flip   = flip;
        bus.spr_en     = en;
        bus.pos_update = 1'b1;
        step();
        bus.pos_update = 1'b0;
    endtask

    task automatic vs_pulse(input logic exp_drawn);
        idle(4);
        bus.vsync = 1'b0;
        step();
        check("spr_drawn_frame_start", bus.spr_drawn, exp_drawn);
        step();
        check("spr_drawn_pulse_width", bus.spr_drawn, 0);
        bus.vsync = 1'b1;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.x_pixel    = '0;
        bus.y_pixel    = '0;
        bus.pix_valid  = 1'b0;
        bus.vsync      = 1'b1;
        bus.bg_data    = '0;
        bus.spr_x      = '0;
        bus.spr_y      = '0;
        bus.spr_frame  = '0;
        bus.spr_flip   = 1'b0;
        bus.spr_en     = 1'b0;
        bus.pos_update = 1'b0;
        #2 Rst_n = 1'b0;
        #3;
        check("reset_pix_out", bus.pix_out, 0);
        check("reset_pix_valid_out", bus.pix_valid_out, 0);
        check("reset_spr_addr", bus.spr_addr, 0);
        check("reset_spr_drawn", bus.spr_drawn, 0);
        repeat (2) step();
        Rst_n = 1'b1;
        step();

        // Sprite never enabled: background passes through unchanged
        px(10'd0,   10'd0,   12'h00F, 12'h00F);
        px(10'd100, 10'd50,  12'h00F, 12'h00F);
        px(10'd639, 10'd479, 12'h00F, 12'h00F);
        idle(2);
        px(10'd320, 10'd240, 12'h00F, 12'h00F);
        check("addr_disabled", bus.spr_addr, 10'h000);

        // Sprite at (100,50), frame 1, no flip
        load(10'd100, 10'd50, 2'd1, 1'b0, 1'b1);
        vs_pulse(1'b0);
        px(10'd100, 10'd50, 12'h0AA, 12'hF00); check("addr_100_50", bus.spr_addr, 10'h100);
        px(10'd115, 10'd65, 12'h0AA, 12'hF00); check("addr_115_65", bus.spr_addr, 10'h1FF);
        px(10'd99,  10'd50, 12'h0AA, 12'h0AA); check("addr_hold_99", bus.spr_addr, 10'h1FF);
        px(10'd116, 10'd50, 12'h0AA, 12'h0AA);
        px(10'd105, 10'd50, 12'h0AA, 12'h0AA); check("addr_transp", bus.spr_addr, 10'h105);
        px(10'd100, 10'd66, 12'h0AA, 12'h0AA);

        // Same position, mirrored
        load(10'd100, 10'd50, 2'd1, 1'b1, 1'b1);
        vs_pulse(1'b1);
        px(10'd100, 10'd50, 12'h055, 12'hF00); check("flip_addr_100", bus.spr_addr, 10'h10F);
        px(10'd115, 10'd50, 12'h055, 12'hF00); check("flip_addr_115", bus.spr_addr, 10'h100);
        px(10'd110, 10'd50, 12'h055, 12'h055); check("flip_addr_110", bus.spr_addr, 10'h105);

        // Bottom-right corner clipping, no wrap to column 0
        load(10'd630, 10'd470, 2'd1, 1'b0, 1'b1);
        vs_pulse(1'b1);
        px(10'd630, 10'd470, 12'h333, 12'hF00); check("corner_addr_630", bus.spr_addr, 10'h100);
        px(10'd639, 10'd479, 12'h333, 12'hF00); check("corner_addr_639", bus.spr_addr, 10'h199);
        px(10'd629, 10'd470, 12'h333, 12'h333);
        px(10'd0,   10'd470, 12'h333, 12'h333);
        px(10'd5,   10'd470, 12'h333, 12'h333); check("corner_nowrap", bus.spr_addr, 10'h199);
        px(10'd635, 10'd475, 12'h333, 12'hF00); check("corner_addr_635", bus.spr_addr, 10'h155);
        px(10'd630, 10'd469, 12'h333, 12'h333);

        // Mid-frame and on-edge shadow updates
        load(10'd100, 10'd50, 2'd1, 1'b0, 1'b1);
        vs_pulse(1'b1);
        px(10'd100, 10'd50, 12'h0C0, 12'hF00);
        load(10'd200, 10'd50, 2'd1, 1'b0, 1'b1);
        px(10'd100, 10'd50, 12'h0C0, 12'hF00);
        px(10'd200, 10'd50, 12'h0C0, 12'h0C0);
        idle(4);
        bus.vsync      = 1'b0;
        bus.spr_x      = 10'd300;
        bus.pos_update = 1'b1;
        step();
        check("spr_drawn_coincident", bus.spr_drawn, 1);
        bus.pos_update = 1'b0;
        step();
        bus.vsync = 1'b1;
        step();
        px(10'd200, 10'd50, 12'h0C0, 12'hF00);
        px(10'd100, 10'd50, 12'h0C0, 12'h0C0);
        px(10'd300, 10'd50, 12'h0C0, 12'h0C0);
        vs_pulse(1'b1);
        px(10'd300, 10'd50, 12'h0C0, 12'hF00);
        px(10'd200, 10'd50, 12'h0C0, 12'h0C0);
        vs_pulse(1'b1);
        vs_pulse(1'b0);

        // Reset while pixels are in flight
        px(10'd0, 10'd0, 12'h123, 12'h123);
        px(10'd1, 10'd0, 12'h123, 12'h123);
        px(10'd2, 10'd0, 12'h123, 12'h123);
        check("pre_reset_valid", bus.pix_valid_out, 1);
        check("pre_reset_pix", bus.pix_out, 12'h123);
        Rst_n = 1'b0;
        #1;
        check("midreset_pix_out", bus.pix_out, 0);
        check("midreset_valid", bus.pix_valid_out, 0);
        sq.delete();
        repeat (2) step();
        Rst_n = 1'b1;
        step();
        vs_pulse(1'b0);
        px(10'd300, 10'd50, 12'h456, 12'h456);
        check("post_reset_addr", bus.spr_addr, 10'h000);
        idle(5);
        check("scoreboard_drained", sq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
